// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the MIPS pipeline and its hazard/flush sequencer.
// The pipeline side is the master; hazard_ctrl is the slave.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_rs;
    logic [4:0]       ID_rt;
    logic             ID_UseRt;
    logic [2:0]       ID_PCSrc;
    logic             ID_Exception;
    logic             EX_MemRead;
    logic [4:0]       EX_WriteAddress;
    logic             MEM_MemRead;
    logic [4:0]       MEM_WriteAddress;
    logic             EX_BranchTaken;
    logic             IRQ;
    logic             KernelMode;
    logic             PC_Write;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             Exc_Take;
    logic             Exc_IRQ;
    logic [CNT_W-1:0] StallCnt;
    logic [CNT_W-1:0] FlushCnt;

    modport master (
        output ID_rs, ID_rt, ID_UseRt, ID_PCSrc, ID_Exception,
        output EX_MemRead, EX_WriteAddress, MEM_MemRead, MEM_WriteAddress,
        output EX_BranchTaken, IRQ, KernelMode,
        input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
        input  Exc_Take, Exc_IRQ, StallCnt, FlushCnt
    );

    modport slave (
        input  ID_rs, ID_rt, ID_UseRt, ID_PCSrc, ID_Exception,
        input  EX_MemRead, EX_WriteAddress, MEM_MemRead, MEM_WriteAddress,
        input  EX_BranchTaken, IRQ, KernelMode,
        output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
        output Exc_Take, Exc_IRQ, StallCnt, FlushCnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and flush sequencer for the 5-stage MIPS pipeline: load-use and jr-on-load
// stalls, taken-branch flush, exception/interrupt entry, saturating perf counters.
module hazard_ctrl #(
    parameter int         CNT_W    = 16,
    parameter logic [2:0] JR_PCSRC = 3'b011
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {RUN, JR_WAIT, EXC_HOLD} state_t;
    typedef enum logic [1:0] {ACT_NORMAL, ACT_STALL, ACT_FLUSH} act_t;

    state_t           state_q, state_d;
    act_t             act;
    logic             irq_q;
    logic             irq_pend_q, irq_pend_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             lu, jr2, jr1, exc;
    logic             exc_take, exc_irq;
    logic             irq_set;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
    endfunction

    assign lu  = hz.EX_MemRead && (hz.EX_WriteAddress != 5'd0) &&
                 ((hz.EX_WriteAddress == hz.ID_rs) ||
                  (hz.ID_UseRt && (hz.EX_WriteAddress == hz.ID_rt)));
    assign jr2 = (hz.ID_PCSrc == JR_PCSRC) && hz.EX_MemRead &&
                 (hz.EX_WriteAddress != 5'd0) && (hz.EX_WriteAddress == hz.ID_rs);
    assign jr1 = (hz.ID_PCSrc == JR_PCSRC) && hz.MEM_MemRead &&
                 (hz.MEM_WriteAddress != 5'd0) && (hz.MEM_WriteAddress == hz.ID_rs);
    assign exc = hz.ID_Exception || (irq_pend_q && !hz.KernelMode);

    always_comb begin
        state_d  = state_q;
        act      = ACT_NORMAL;
        exc_take = 1'b0;
        exc_irq  = 1'b0;
        case (state_q)
            JR_WAIT: begin
                act     = hz.EX_BranchTaken ? ACT_FLUSH : ACT_STALL;
                state_d = RUN;
            end
            default: begin
                // EXC_HOLD behaves like RUN except that a new exception cannot be taken
                state_d = RUN;
                if (hz.EX_BranchTaken) begin
                    act = ACT_FLUSH;
                end else if ((state_q != EXC_HOLD) && exc) begin
                    act      = ACT_FLUSH;
                    exc_take = 1'b1;
                    exc_irq  = !hz.ID_Exception;
                    state_d  = EXC_HOLD;
                end else if (jr2) begin
                    act     = ACT_STALL;
                    state_d = JR_WAIT;
                end else if (lu || jr1) begin
                    act = ACT_STALL;
                end
            end
        endcase
    end

    // Interrupt edges are dropped while holding after an exception entry
    assign irq_set     = hz.IRQ && !irq_q && (state_q != EXC_HOLD);
    assign irq_pend_d  = irq_set || (irq_pend_q && !(exc_take && exc_irq));
    assign stall_cnt_d = sat_inc(stall_cnt_q, act == ACT_STALL);
    assign flush_cnt_d = sat_inc(flush_cnt_q, act == ACT_FLUSH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            irq_q       <= 1'b0;
            irq_pend_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            irq_q       <= hz.IRQ;
            irq_pend_q  <= irq_pend_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        hz.PC_Write    = 1'b1;
        hz.IF_ID_Write = 1'b1;
        hz.IF_ID_Flush = 1'b0;
        hz.ID_EX_Flush = 1'b0;
        hz.Exc_Take    = exc_take;
        hz.Exc_IRQ     = exc_irq;
        if (!reset) begin
            hz.PC_Write    = 1'b0;
            hz.IF_ID_Write = 1'b0;
            hz.IF_ID_Flush = 1'b1;
            hz.ID_EX_Flush = 1'b1;
            hz.Exc_Take    = 1'b0;
            hz.Exc_IRQ     = 1'b0;
        end else if (act == ACT_STALL) begin
            hz.PC_Write    = 1'b0;
            hz.IF_ID_Write = 1'b0;
            hz.ID_EX_Flush = 1'b1;
        end else if (act == ACT_FLUSH) begin
            hz.IF_ID_Flush = 1'b1;
            hz.ID_EX_Flush = 1'b1;
        end
    end

    assign hz.StallCnt = stall_cnt_q;
    assign hz.FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus a randomized
// run, both checked each cycle against a rule-level model; a CNT_W=2 copy shows saturation.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(16)) hz ();
    hazard_ctrl_if #(.CNT_W(2))  hs ();

    hazard_ctrl #(.CNT_W(16), .JR_PCSRC(3'b011)) dut     (.clk(clk), .reset(reset), .hz(hz));
    hazard_ctrl #(.CNT_W(2),  .JR_PCSRC(3'b011)) dut_sat (.clk(clk), .reset(reset), .hz(hs));

    assign hs.ID_rs            = hz.ID_rs;
    assign hs.ID_rt            = hz.ID_rt;
    assign hs.ID_UseRt         = hz.ID_UseRt;
    assign hs.ID_PCSrc         = hz.ID_PCSrc;
    assign hs.ID_Exception     = hz.ID_Exception;
    assign hs.EX_MemRead       = hz.EX_MemRead;
    assign hs.EX_WriteAddress  = hz.EX_WriteAddress;
    assign hs.MEM_MemRead      = hz.MEM_MemRead;
    assign hs.MEM_WriteAddress = hz.MEM_WriteAddress;
    assign hs.EX_BranchTaken   = hz.EX_BranchTaken;
    assign hs.IRQ              = hz.IRQ;
    assign hs.KernelMode       = hz.KernelMode;

    logic [5:0] o1, o2;
    assign o1 = {hz.PC_Write, hz.IF_ID_Write, hz.IF_ID_Flush, hz.ID_EX_Flush, hz.Exc_Take, hz.Exc_IRQ};
    assign o2 = {hs.PC_Write, hs.IF_ID_Write, hs.IF_ID_Flush, hs.ID_EX_Flush, hs.Exc_Take, hs.Exc_IRQ};

    localparam logic [5:0] O_NORMAL = 6'b110000;
    localparam logic [5:0] O_STALL  = 6'b000100;
    localparam logic [5:0] O_FLUSH  = 6'b111100;
    localparam logic [5:0] O_RESET  = 6'b001100;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what each cycle must do, derived from the hazard rules
    bit m_jr, m_hold, m_pend, m_prev;
    int m_stall, m_flush;
    bit b_br, b_lu, b_jr2, b_jr1, b_exc, b_take, b_irqc, b_nxt_jr;
    int act;
    logic [5:0] e;

    always @(negedge clk) begin
        if (!reset) begin
            check("rst_outs", {26'd0, o1}, {26'd0, O_RESET});
            check("rst_outs_sat", {26'd0, o2}, {26'd0, O_RESET});
            check("rst_stall", {16'd0, hz.StallCnt}, 0);
            check("rst_flush", {16'd0, hz.FlushCnt}, 0);
            m_jr = 0; m_hold = 0; m_pend = 0; m_prev = 0; m_stall = 0; m_flush = 0;
        end else begin
            b_br  = hz.EX_BranchTaken;
            b_lu  = hz.EX_MemRead && hz.EX_WriteAddress != 0 &&
                    (hz.EX_WriteAddress == hz.ID_rs || (hz.ID_UseRt && hz.EX_WriteAddress == hz.ID_rt));
            b_jr2 = hz.ID_PCSrc == 3'b011 && hz.EX_MemRead && hz.EX_WriteAddress != 0 &&
                    hz.EX_WriteAddress == hz.ID_rs;
            b_jr1 = hz.ID_PCSrc == 3'b011 && hz.MEM_MemRead && hz.MEM_WriteAddress != 0 &&
                    hz.MEM_WriteAddress == hz.ID_rs;
            b_exc = hz.ID_Exception || (m_pend && !hz.KernelMode);
            act = 0; b_take = 0; b_irqc = 0; b_nxt_jr = 0;
            if (m_jr) act = b_br ? 2 : 1;
            else if (b_br) act = 2;
            else if (!m_hold && b_exc) begin act = 2; b_take = 1; b_irqc = !hz.ID_Exception; end
            else if (b_jr2) begin act = 1; b_nxt_jr = 1; end
            else if (b_lu || b_jr1) act = 1;
            case (act)
                0: e = O_NORMAL;
                1: e = O_STALL;
                default: e = {4'b1111, b_take, b_irqc};
            endcase
            check("outs", {26'd0, o1}, {26'd0, e});
            check("outs_sat", {26'd0, o2}, {26'd0, e});
            check("StallCnt", {16'd0, hz.StallCnt}, m_stall);
            check("FlushCnt", {16'd0, hz.FlushCnt}, m_flush);
            check("StallCnt_sat", {30'd0, hs.StallCnt}, (m_stall > 3) ? 3 : m_stall);
            check("FlushCnt_sat", {30'd0, hs.FlushCnt}, (m_flush > 3) ? 3 : m_flush);
            m_pend = (hz.IRQ && !m_prev && !m_hold) || (m_pend && !(b_take && b_irqc));
            m_prev = hz.IRQ;
            m_jr   = b_nxt_jr;
            m_hold = b_take;
            if (act == 1 && m_stall < 65535) m_stall++;
            if (act == 2 && m_flush < 65535) m_flush++;
        end
    end

    task automatic idle();
        hz.ID_rs = 0; hz.ID_rt = 0; hz.ID_UseRt = 0; hz.ID_PCSrc = 0; hz.ID_Exception = 0;
        hz.EX_MemRead = 0; hz.EX_WriteAddress = 0; hz.MEM_MemRead = 0; hz.MEM_WriteAddress = 0;
        hz.EX_BranchTaken = 0; hz.IRQ = 0; hz.KernelMode = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use(input logic [4:0] r);
        idle();
        hz.EX_MemRead = 1; hz.EX_WriteAddress = r; hz.ID_rs = r;
    endtask

    task automatic jr_load(input logic [4:0] r);
        idle();
        hz.ID_PCSrc = 3'b011; hz.ID_rs = r; hz.EX_MemRead = 1; hz.EX_WriteAddress = r;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        repeat (2) cyc();
        #3 check("rst_lit", {26'd0, o1}, {26'd0, O_RESET});
        cyc();
        reset = 1'b1;

        // Load-use on rs
        cyc(); load_use(5'd8);
        #3 check("lu_stall", {26'd0, o1}, {26'd0, O_STALL});
        cyc(); idle();
        #3 check("lu_cnt", {16'd0, hz.StallCnt}, 1);
        check("lu_after", {26'd0, o1}, {26'd0, O_NORMAL});

        // Load-use on rt, gated by ID_UseRt; $zero never stalls
        cyc(); idle(); hz.EX_MemRead = 1; hz.EX_WriteAddress = 8; hz.ID_rs = 1; hz.ID_rt = 8;
        #3 check("rt_nouse", {26'd0, o1}, {26'd0, O_NORMAL});
        cyc(); hz.ID_UseRt = 1;
        #3 check("rt_use", {26'd0, o1}, {26'd0, O_STALL});
        cyc(); idle(); hz.EX_MemRead = 1; hz.ID_UseRt = 1;
        #3 check("r0_nostall", {26'd0, o1}, {26'd0, O_NORMAL});

        // jr on a load in EX: two stall cycles
        cyc(); jr_load(5'd9);
        #3 check("jr_stall1", {26'd0, o1}, {26'd0, O_STALL});
        cyc(); idle();
        #3 check("jr_stall2", {26'd0, o1}, {26'd0, O_STALL});
        cyc();
        #3 check("jr_done", {26'd0, o1}, {26'd0, O_NORMAL});
        check("jr_cnt", {16'd0, hz.StallCnt}, 4);

        // Taken branch outranks exception and load-use
        cyc(); load_use(5'd8); hz.EX_BranchTaken = 1; hz.ID_Exception = 1;
        #3 check("br_pri", {26'd0, o1}, {26'd0, O_FLUSH});
        cyc(); idle();
        #3 check("br_flushcnt", {16'd0, hz.FlushCnt}, 1);
        check("br_stallcnt", {16'd0, hz.StallCnt}, 4);

        // Interrupt edge, taken the next cycle, no retrigger while held
        cyc(); hz.IRQ = 1;
        #3 check("irq_edge", {26'd0, o1}, {26'd0, O_NORMAL});
        cyc();
        #3 check("irq_take", {26'd0, o1}, {26'd0, 6'b111111});
        cyc();
        #3 check("irq_hold", {26'd0, o1}, {26'd0, O_NORMAL});
        cyc();
        #3 check("irq_noretrig", {26'd0, o1}, {26'd0, O_NORMAL});
        check("irq_flushcnt", {16'd0, hz.FlushCnt}, 2);

        // Kernel mode masks a pending interrupt until it drops
        cyc(); hz.IRQ = 0; hz.KernelMode = 1;
        cyc(); hz.IRQ = 1;
        cyc();
        #3 check("kmask", {26'd0, o1}, {26'd0, O_NORMAL});
        cyc(); hz.KernelMode = 0;
        #3 check("kunmask", {26'd0, o1}, {26'd0, 6'b111111});
        cyc(); idle();
        #3 check("k_flushcnt", {16'd0, hz.FlushCnt}, 3);

        // Asynchronous reset in the middle of the jr wait cycle
        cyc(); jr_load(5'd9);
        cyc(); idle();
        #1 reset = 1'b0;
        #1 check("arst_outs", {26'd0, o1}, {26'd0, O_RESET});
        check("arst_stall", {16'd0, hz.StallCnt}, 0);
        check("arst_flush", {16'd0, hz.FlushCnt}, 0);
        cyc(); cyc();
        reset = 1'b1;
        #3 check("arst_abort", {26'd0, o1}, {26'd0, O_NORMAL});

        // Saturation of the 2-bit counter copy
        for (int i = 0; i < 5; i++) begin
            cyc(); load_use(5'd3);
        end
        cyc(); idle();
        #3 check("sat_stall2", {30'd0, hs.StallCnt}, 3);
        check("sat_stall16", {16'd0, hz.StallCnt}, 5);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc();
            hz.ID_rs            = 5'($urandom_range(0, 3));
            hz.ID_rt            = 5'($urandom_range(0, 3));
            hz.ID_UseRt         = 1'($urandom_range(0, 1));
            hz.ID_PCSrc         = ($urandom_range(0, 2) == 0) ? 3'b011 : 3'($urandom_range(0, 7));
            hz.ID_Exception     = ($urandom_range(0, 19) == 0);
            hz.EX_MemRead       = 1'($urandom_range(0, 1));
            hz.EX_WriteAddress  = 5'($urandom_range(0, 3));
            hz.MEM_MemRead      = 1'($urandom_range(0, 1));
            hz.MEM_WriteAddress = 5'($urandom_range(0, 3));
            hz.EX_BranchTaken   = ($urandom_range(0, 9) == 0);
            hz.KernelMode       = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 7) == 0) hz.IRQ = ~hz.IRQ;
        end
        cyc(); idle();
        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
